wb_result_arbiter: RTL and testbench
====================================

Name: wb_result_arbiter

Overview:
- Parametrised writeback arbiter between NUM_PIPES execution pipes and the single register-file write port (WB -> IX).
- Generalises the fixed ALU/LSU/MUL/DIV writeback priority to N pipes.
- Adds per-pipe result buffering with valid/ready backpressure.
- Adds a selectable fixed-priority or round-robin arbitration mode.

Parameters:
- NUM_PIPES, 4, number of execution pipes; pipe index i = EXE pipe ID, and index 0 has highest fixed priority.
- FIFO_DEPTH, 2, entries per pipe result FIFO; power of two, >= 2.
- DATA_W, 32, result width.
- REG_W, 5, destination register index width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_PIPES  per-pipe result valid.
- in_ready  out  NUM_PIPES  per-pipe FIFO not full.
- in_wr_en  in  NUM_PIPES  per-pipe result writes a register.
- in_rd  in  NUM_PIPES*REG_W  packed destination registers; pipe i at [i*REG_W +: REG_W].
- in_data  in  NUM_PIPES*DATA_W  packed results; pipe i at [i*DATA_W +: DATA_W].
- wb_wr_en  out  1  register-file write enable (registered).
- wb_rd  out  REG_W  destination register (registered).
- wb_wr_data  out  DATA_W  write data (registered).
- wb_grant  out  NUM_PIPES  one-hot source pipe of current wb_* beat; zero when idle.
- stall_cnt  out  NUM_PIPES*16  per-pipe stall counters; present only with WB_ARB_STALL_CNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all FIFOs empty; wb_wr_en=0, wb_rd=0, wb_wr_data=0, wb_grant=0.
  - round-robin pointer = NUM_PIPES-1, so pipe 0 is first.
  - stall_cnt=0.
  - Reset mid-operation discards all buffered results.
- Push:
  - in_ready[i] = !full[i], where full means FIFO_DEPTH entries are stored.
  - An entry is accepted when in_valid[i] && in_ready[i].
  - A full FIFO deasserts ready even if it pops the same cycle; there is no pop-through.
  - An accepted entry with in_wr_en[i]=0 or in_rd[i]=0 is discarded: no write, no arbitration slot.
- Arbitration, every cycle, over the non-empty FIFOs (combinational on registered FIFO heads):
  - RR_MODE=0: the lowest index wins.
  - RR_MODE=1: search starts at pointer+1 modulo NUM_PIPES and the first non-empty pipe wins. The pointer loads the winner index only on a grant; it holds when idle.
- Pop and output:
  - The winner's head pops.
  - Next edge: wb_wr_en=1, wb_rd/wb_wr_data = head fields, wb_grant = one-hot winner.
  - With no winner, next edge gives wb_wr_en=0 and wb_grant=0. wb_rd and wb_wr_data hold their last values.
- Throughput and latency:
  - Exactly one result per cycle at most; the output port is never stalled.
  - Minimum latency: accepted at edge k, on wb_* after edge k+1.
- FIFO pointers:
  - log2(FIFO_DEPTH)+1-bit read/write pointers that wrap naturally.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count.
  - Push into an empty FIFO is not visible to arbitration until the next cycle.
- Per-pipe ordering is preserved (FIFO). No ordering is guaranteed across pipes.

Optional Feature:
- Macro: WB_ARB_STALL_CNT_EN.
- Defined: stall_cnt port exists.
  - Counter i increments each cycle FIFO i is non-empty and not granted.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: port, counters and associated logic are absent; all other behaviour is identical.

Test Plan:
- Fixed priority, RR_MODE=0, NUM_PIPES=4: same edge, pipe0 (rd=3, data=0x11), pipe2 (rd=4, 0x22), pipe3 (rd=5, 0x33) -> wb beats in order rd3/0x11 grant=0001, rd4/0x22 grant=0100, rd5/0x33 grant=1000 on three consecutive cycles, first beat one cycle after acceptance.
- Round-robin, RR_MODE=1: all four pipes hold 2 entries after reset -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, then wb_wr_en=0 and wb_grant=0.
- Backpressure, FIFO_DEPTH=2, fixed mode: pipe0 pushes every cycle while pipe3 pushes 0xAA, 0xBB, 0xCC -> in_ready[3] low after two accepts; 0xCC held until a slot frees; pipe3 beats emerge only when pipe0 is empty, in order AA, BB, CC.
- Discard: pipe1 pushes rd=0 data=0xDEAD, then wr_en=0 rd=7 -> no wb_wr_en pulse, FIFO stays empty, in_ready[1] stays high.
- Async reset mid-operation: rst_n low between edges with 3 buffered entries -> outputs zero immediately; after release, no stale beat appears and the first new push emerges normally.
- WB_ARB_STALL_CNT_EN, fixed mode: pipe0 continuously non-empty for 70000 cycles with pipe2 holding one entry -> stall_cnt[2] saturates at 0xFFFF; stall_cnt[0]=0.

Source files
------------

// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: per-pipe result FIFOs feeding one register-file write port.
// Define WB_ARB_STALL_CNT_EN to add saturating per-pipe stall counters.

module wb_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_W-1:0]  push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [REG_W-1:0]  head_rd,
  output logic [DATA_W-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wptr_q, wptr_d;
  logic [AW:0]                  rptr_q, rptr_d;
  logic [DEPTH-1:0][REG_W-1:0]  rd_mem;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign head_rd   = rd_mem[rptr_q[AW-1:0]];
  assign head_data = data_mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + (AW+1)'(1);
    if (pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q[AW-1:0]]   <= push_rd;
      data_mem[wptr_q[AW-1:0]] <= push_data;
    end
  end
endmodule

module wb_result_arbiter #(
  parameter int NUM_PIPES  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int RR_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PIPES-1:0]          in_valid,
  output logic [NUM_PIPES-1:0]          in_ready,
  input  logic [NUM_PIPES-1:0]          in_wr_en,
  input  logic [NUM_PIPES*REG_W-1:0]    in_rd,
  input  logic [NUM_PIPES*DATA_W-1:0]   in_data,
  output logic                          wb_wr_en,
  output logic [REG_W-1:0]              wb_rd,
  output logic [DATA_W-1:0]             wb_wr_data,
  output logic [NUM_PIPES-1:0]          wb_grant
`ifdef WB_ARB_STALL_CNT_EN
  ,
  output logic [NUM_PIPES*16-1:0]       stall_cnt
`endif
);
  localparam int PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic [NUM_PIPES-1:0]              full, empty, push, gnt;
  logic [NUM_PIPES-1:0][REG_W-1:0]   head_rd;
  logic [NUM_PIPES-1:0][DATA_W-1:0]  head_data;
  logic [PW-1:0]                     win_idx;
  logic                              found;
  logic [REG_W-1:0]                  sel_rd;
  logic [DATA_W-1:0]                 sel_data;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 wb_wr_en_q, wb_wr_en_d;
  logic [REG_W-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [NUM_PIPES-1:0] wb_grant_q, wb_grant_d;

  assign in_ready = ~full;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    // Results with no architectural write never occupy a slot.
    assign push[i] = in_valid[i] & ~full[i] & in_wr_en[i]
                   & (in_rd[i*REG_W +: REG_W] != '0);

    wb_result_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_rd   (in_rd[i*REG_W +: REG_W]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (gnt[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_rd   (head_rd[i]),
      .head_data (head_data[i])
    );
  end

  // Search order starts at 0 (fixed) or one past the last winner (round-robin).
  always_comb begin
    int idx;
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (RR_MODE != 0) begin
        idx = int'(rr_ptr_q) + 1 + k;
        if (idx >= NUM_PIPES) idx = idx - NUM_PIPES;
      end else begin
        idx = k;
      end
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = PW'(idx);
      end
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (gnt[k]) begin
        sel_rd   = sel_rd | head_rd[k];
        sel_data = sel_data | head_data[k];
      end
    end
  end

  always_comb begin
    wb_wr_en_d = found;
    wb_grant_d = gnt;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (found) begin
      wb_rd_d   = sel_rd;
      wb_data_d = sel_data;
      rr_ptr_d  = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= PW'(NUM_PIPES - 1);
      wb_wr_en_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_grant_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_grant_q <= wb_grant_d;
    end
  end

  assign wb_wr_en   = wb_wr_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_wr_data = wb_data_q;
  assign wb_grant   = wb_grant_q;

`ifdef WB_ARB_STALL_CNT_EN
  logic [NUM_PIPES-1:0][15:0] stall_q, stall_d;

  // A pipe stalls when it has a result waiting but lost arbitration.
  always_comb begin
    stall_d = stall_q;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (!empty[k] && !gnt[k] && (stall_q[k] != 16'hFFFF))
        stall_d[k] = stall_q[k] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter: fixed-priority and round-robin instances on shared inputs.
module tb_wb_result_arbiter;
  localparam int NP = 4;
  localparam int RW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    in_valid, in_wr_en;
  logic [NP*RW-1:0] in_rd;
  logic [NP*DW-1:0] in_data;

  logic [NP-1:0]    in_ready, wb_grant;
  logic             wb_wr_en;
  logic [RW-1:0]    wb_rd;
  logic [DW-1:0]    wb_wr_data;

  logic [NP-1:0]    in_ready_rr, wb_grant_rr;
  logic             wb_wr_en_rr;
  logic [RW-1:0]    wb_rd_rr;
  logic [DW-1:0]    wb_wr_data_rr;
`ifdef WB_ARB_STALL_CNT_EN
  logic [NP*16-1:0] stall_cnt, stall_cnt_rr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_result_arbiter #(.NUM_PIPES(NP), .FIFO_DEPTH(2), .DATA_W(DW), .REG_W(RW), .RR_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_wr_en(in_wr_en),
    .in_rd(in_rd), .in_data(in_data), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_wr_data(wb_wr_data), .wb_grant(wb_grant)
`ifdef WB_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  wb_result_arbiter #(.NUM_PIPES(NP), .FIFO_DEPTH(2), .DATA_W(DW), .REG_W(RW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_rr), .in_wr_en(in_wr_en),
    .in_rd(in_rd), .in_data(in_data), .wb_wr_en(wb_wr_en_rr), .wb_rd(wb_rd_rr),
    .wb_wr_data(wb_wr_data_rr), .wb_grant(wb_grant_rr)
`ifdef WB_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt_rr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_wr_en = '0;
    in_rd    = '0;
    in_data  = '0;
  endtask

  task automatic set_pipe(input int p, input logic [RW-1:0] rd, input logic [DW-1:0] d,
                          input logic we);
    in_valid[p]          = 1'b1;
    in_wr_en[p]          = we;
    in_rd[p*RW +: RW]    = rd;
    in_data[p*DW +: DW]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    #12;
    chk("rst_wr_en", wb_wr_en, 0);
    chk("rst_grant", wb_grant, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_wr_data, 0);
    chk("rst_ready", in_ready, 4'hF);
    #2 rst_n = 1'b1;
    step();

    // Fixed priority: three pipes accepted on the same edge.
    set_pipe(0, 5'd3, 32'h11, 1'b1);
    set_pipe(2, 5'd4, 32'h22, 1'b1);
    set_pipe(3, 5'd5, 32'h33, 1'b1);
    step();
    clear_in();
    chk("fp_accept_edge_idle", wb_wr_en, 0);
    step();
    chk("fp_b0_en", wb_wr_en, 1);
    chk("fp_b0_grant", wb_grant, 4'b0001);
    chk("fp_b0_rd", wb_rd, 3);
    chk("fp_b0_data", wb_wr_data, 32'h11);
    step();
    chk("fp_b1_grant", wb_grant, 4'b0100);
    chk("fp_b1_rd", wb_rd, 4);
    chk("fp_b1_data", wb_wr_data, 32'h22);
    step();
    chk("fp_b2_grant", wb_grant, 4'b1000);
    chk("fp_b2_rd", wb_rd, 5);
    chk("fp_b2_data", wb_wr_data, 32'h33);
    step();
    chk("fp_idle_en", wb_wr_en, 0);
    chk("fp_idle_grant", wb_grant, 0);
    chk("fp_idle_rd_hold", wb_rd, 5);
    chk("fp_idle_data_hold", wb_wr_data, 32'h33);

    // Round-robin: every pipe holds two entries.
    do_reset();
    for (int p = 0; p < NP; p++) set_pipe(p, RW'(8 + p), DW'(32'h100 + p), 1'b1);
    step();
    for (int p = 0; p < NP; p++) set_pipe(p, RW'(8 + p), DW'(32'h200 + p), 1'b1);
    step();
    clear_in();
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      chk("rr_grant", wb_grant_rr, 64'(1 << (j % 4)));
      chk("rr_data", wb_wr_data_rr, (j < 4) ? 64'(32'h100 + j) : 64'(32'h200 + j - 4));
    end
    step();
    chk("rr_idle_en", wb_wr_en_rr, 0);
    chk("rr_idle_grant", wb_grant_rr, 0);

    // Backpressure: pipe0 streams, pipe3 fills and starves.
    do_reset();
    set_pipe(0, 5'd1, 32'h0, 1'b1);
    set_pipe(3, 5'd6, 32'hAA, 1'b1);
    step();
    set_pipe(0, 5'd1, 32'h1, 1'b1);
    set_pipe(3, 5'd6, 32'hBB, 1'b1);
    step();
    chk("bp_rdy3_full", in_ready[3], 0);
    chk("bp_g0_first", wb_grant, 4'b0001);
    set_pipe(3, 5'd6, 32'hCC, 1'b1);
    for (int c = 0; c < 5; c++) begin
      set_pipe(0, 5'd1, DW'(c + 2), 1'b1);
      step();
      chk("bp_rdy3_hold", in_ready[3], 0);
      chk("bp_g0_stream", wb_grant, 4'b0001);
    end
    in_valid[0] = 1'b0;
    step();
    chk("bp_g0_last", wb_grant, 4'b0001);
    chk("bp_rdy3_still_full", in_ready[3], 0);
    step();
    chk("bp_aa_grant", wb_grant, 4'b1000);
    chk("bp_aa_data", wb_wr_data, 32'hAA);
    chk("bp_rdy3_free", in_ready[3], 1);
    step();
    clear_in();
    chk("bp_bb_data", wb_wr_data, 32'hBB);
    step();
    chk("bp_cc_grant", wb_grant, 4'b1000);
    chk("bp_cc_data", wb_wr_data, 32'hCC);
    step();
    chk("bp_idle", wb_wr_en, 0);

    // Discard: rd=0 and wr_en=0 results never reach the port.
    do_reset();
    set_pipe(1, 5'd0, 32'hDEAD, 1'b1);
    step();
    chk("disc_rdy1_a", in_ready[1], 1);
    set_pipe(1, 5'd7, 32'hBEEF, 1'b0);
    step();
    clear_in();
    chk("disc_rdy1_b", in_ready[1], 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("disc_no_wb", wb_wr_en, 0);
      chk("disc_rdy1", in_ready[1], 1);
    end

    // Asynchronous reset with three results still buffered.
    do_reset();
    for (int p = 0; p < NP; p++) set_pipe(p, RW'(1 + p), DW'(32'hA0 + p), 1'b1);
    step();
    clear_in();
    step();
    chk("ar_pre_en", wb_wr_en, 1);
    chk("ar_pre_data", wb_wr_data, 32'hA0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", wb_wr_en, 0);
    chk("ar_grant", wb_grant, 0);
    chk("ar_rd", wb_rd, 0);
    chk("ar_data", wb_wr_data, 0);
    chk("ar_ready", in_ready, 4'hF);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ar_no_stale", wb_wr_en, 0);
    end
    set_pipe(2, 5'd9, 32'h55, 1'b1);
    step();
    clear_in();
    chk("ar_new_lat", wb_wr_en, 0);
    step();
    chk("ar_new_grant", wb_grant, 4'b0100);
    chk("ar_new_rd", wb_rd, 9);
    chk("ar_new_data", wb_wr_data, 32'h55);

`ifdef WB_ARB_STALL_CNT_EN
    // pipe2 waits behind a permanently busy pipe0.
    do_reset();
    set_pipe(0, 5'd1, 32'h0, 1'b1);
    set_pipe(2, 5'd2, 32'h77, 1'b1);
    step();
    in_valid[2] = 1'b0;
    repeat (10) step();
    chk("sc_p2_10", stall_cnt[2*16 +: 16], 10);
    chk("sc_p0_10", stall_cnt[0 +: 16], 0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sc_p2_sat", stall_cnt[2*16 +: 16], 16'hFFFF);
    chk("sc_p0_zero", stall_cnt[0 +: 16], 0);
    chk("sc_p1_zero", stall_cnt[1*16 +: 16], 0);
    chk("sc_grant0", wb_grant, 4'b0001);
    clear_in();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
